// File: rtl/spi_master_driver_bfm.sv
// rtl/spi_master_driver_bfm.sv - SPI master: one parallel request becomes a full CS/SCLK/MOSI/MISO frame
module spi_master_driver_bfm #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLK_DIV      = 2,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int NO_OF_SLAVES = 1
) (
  input  logic                            pclk,
  input  logic                            areset,
  input  logic                            cpol,
  input  logic                            cpha,
  input  logic                            lsb_first,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [DATA_WIDTH-1:0]           req_data,
  input  logic [$clog2(NO_OF_SLAVES):0]   req_cs_sel,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            busy,
  output logic                            sclk,
  output logic [NO_OF_SLAVES-1:0]         cs,
  output logic                            mosi,
  input  logic                            miso
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int HW = $clog2(2 * DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state;
  logic                  cpol_l, cpha_l, lsb_l;
  logic [DATA_WIDTH-1:0] data_l, rx;
  logic [15:0]           cnt;
  logic [HW-1:0]         half;
  logic [BW-1:0]         pair;
  logic                  last_toggle;

  function automatic logic [BW-1:0] bit_idx(input logic lsb, input logic [BW-1:0] i);
    return lsb ? i : BW'(DATA_WIDTH - 1) - i;
  endfunction

  // pair = which data bit the current sclk period carries
  assign pair        = BW'(half >> 1);
  assign last_toggle = (half == HW'(2 * DATA_WIDTH - 1));

  always_ff @(posedge pclk) begin
    if (areset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      sclk      <= 1'b0;
      cs        <= '1;
      mosi      <= 1'b0;
      cnt       <= '0;
      half      <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      lsb_l     <= 1'b0;
      data_l    <= '0;
      rx        <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          sclk      <= cpol;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          cnt       <= '0;
          half      <= '0;
          if (req_valid && req_ready) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cpol_l    <= cpol;
            cpha_l    <= cpha;
            lsb_l     <= lsb_first;
            data_l    <= req_data;
            rx        <= '0;
            for (int i = 0; i < NO_OF_SLAVES; i++) cs[i] <= (int'(req_cs_sel) != i);
            mosi      <= req_data[bit_idx(lsb_first, '0)];
          end
        end
        SETUP: begin
          if (cnt == 16'(CS_SETUP - 1)) begin
            state <= XFER;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        XFER: begin
          if (cnt == 16'(CLK_DIV - 1)) begin
            cnt  <= '0;
            sclk <= ~sclk;
            // even half = leading toggle; sample edge is leading for cpha=0, trailing for cpha=1
            if (half[0] == cpha_l) rx[bit_idx(lsb_l, pair)] <= miso;
            else if (cpha_l) mosi <= data_l[bit_idx(lsb_l, pair)];
            else if (!last_toggle) mosi <= data_l[bit_idx(lsb_l, BW'(pair + 1'b1))];
            if (last_toggle) begin
              state <= HOLD;
              sclk  <= cpol_l;
            end else half <= half + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        HOLD: begin
          if (cnt == 16'(CS_HOLD - 1)) begin
            state     <= IDLE;
            cs        <= '1;
            rsp_valid <= 1'b1;
            rsp_data  <= rx;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            half      <= '0;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_driver_bfm.sv
// tb/tb_spi_master_driver_bfm.sv - table-driven and randomized checks of the SPI master against a behavioural slave
module tb_spi_master_driver_bfm;
  localparam int NS = 4;

  logic       pclk = 1'b0, areset = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic       req_valid = 1'b0, req_valid2 = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic [2:0] req_cs_sel = 3'd0;
  logic       req_ready, rsp_valid, busy, sclk, mosi, miso;
  logic [7:0] rsp_data;
  logic [NS-1:0] cs;
  logic       req_ready2, rsp_valid2, busy2, sclk2, mosi2;
  logic [7:0] rsp_data2;
  logic [0:0] cs2;
  int         vectors = 0, miscompares = 0, cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  spi_master_driver_bfm #(.NO_OF_SLAVES(NS)) dut (
    .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_cs_sel(req_cs_sel),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso));

  spi_master_driver_bfm #(.CLK_DIV(1)) dut2 (
    .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_data(req_data), .req_cs_sel(1'b0),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .busy(busy2), .sclk(sclk2), .cs(cs2),
    .mosi(mosi2), .miso(mosi2));

  // Behavioural slave: counts sclk toggles while selected, shifts its word out and collects mosi
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  logic       s_cpha = 1'b0, s_lsb = 1'b0, loop_en = 1'b0, miso_s = 1'b0, in_frame = 1'b0;
  logic       cs_all;
  int         tog = 0;
  assign cs_all = &cs;
  assign miso   = loop_en ? mosi : miso_s;

  function automatic int bidx(input logic lsb, input int j);
    return lsb ? j : 7 - j;
  endfunction

  always @(sclk or cs_all) begin
    if (cs_all) in_frame = 1'b0;
    else if (!in_frame) begin
      in_frame = 1'b1;
      tog = 0;
      s_rx = 8'h00;
      if (!s_cpha) miso_s = s_tx[bidx(s_lsb, 0)];
    end else begin
      tog++;
      if (((tog % 2) == 1) != s_cpha) s_rx[bidx(s_lsb, (tog - 1) / 2)] = mosi;
      else if (s_cpha) miso_s = s_tx[bidx(s_lsb, (tog - 1) / 2)];
      else if ((tog - 1) / 2 < 7) miso_s = s_tx[bidx(s_lsb, (tog - 1) / 2 + 1)];
    end
  end

  typedef struct packed {
    logic       cpol, cpha, lsb, loop;
    logic [2:0] sel;
    logic [7:0] data, sw, exp_rsp;
    logic [3:0] exp_cs;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int n, lat;
    logic [3:0] cs_min;
    logic [7:0] got;
    bit seen;
    lat = -1; got = 8'h00; seen = 0;
    @(negedge pclk);
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb;
    s_cpha = v.cpha; s_lsb = v.lsb; s_tx = v.sw; loop_en = v.loop;
    @(negedge pclk);
    check("idle_sclk", sclk, v.cpol);
    req_valid = 1'b1; req_data = v.data; req_cs_sel = v.sel;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge pclk);
    check("accept", req_ready, 1);
    @(negedge pclk);
    req_valid = 1'b0; n = cyc;
    // mode inputs wiggle mid-frame; the latched values must win
    cpol = ~cpol; cpha = ~cpha; lsb_first = ~lsb_first; req_data = ~req_data;
    check("busy", busy, 1);
    cs_min = cs;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge pclk);
      cs_min &= cs;
      if (rsp_valid) begin
        seen = 1; lat = cyc - n; got = rsp_data;
        check("ready_with_rsp", {req_ready, cs_all}, 2'b11);
      end
    end
    check("latency", lat, 36);
    check("rsp_data", got, v.exp_rsp);
    check("cs_sel", cs_min, v.exp_cs);
    if (v.sel < NS) check("slave_rx", s_rx, v.data);
  endtask

  initial begin
    vec_t tbl [5];
    vec_t v;
    int n, rsps, high, t1, cnt_rsp, toggles, first, last;
    bit drop, seen;
    logic prev;
    logic [7:0] got;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'hA5, 8'h00, 8'hA5, 4'b1110};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h5A, 8'h3C, 8'h3C, 4'b1101};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'hC3, 8'h96, 8'h96, 4'b1011};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 8'h0F, 8'hE1, 8'hE1, 4'b0111};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h77, 8'h00, 8'h77, 4'b1111};

    repeat (3) @(negedge pclk);
    check("rst_outputs", {req_ready, rsp_valid, rsp_data, busy, sclk, cs, mosi},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'hF, 1'b0});
    check("rst_outputs2", {req_ready2, rsp_valid2, busy2, sclk2, cs2, mosi2}, 6'b000010);
    areset = 1'b0;
    repeat (2) @(negedge pclk);
    check("ready_after_reset", req_ready, 1);

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    for (int i = 0; i < 24; i++) begin
      v.cpol = 1'($urandom); v.cpha = 1'($urandom); v.lsb = 1'($urandom); v.loop = 1'b0;
      v.sel = 3'($urandom_range(0, NS - 1));
      v.data = 8'($urandom); v.sw = 8'($urandom);
      v.exp_rsp = v.sw;
      v.exp_cs = ~(4'b0001 << v.sel);
      run_frame(v);
    end

    // back-to-back with req_valid held high
    @(negedge pclk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
    s_tx = 8'h55; loop_en = 1'b0; req_cs_sel = 3'd0;
    @(negedge pclk);
    req_valid = 1'b1; req_data = 8'h01;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge pclk);
    @(negedge pclk);
    req_data = 8'h80;
    rsps = 0; high = 0; t1 = 0; drop = 0;
    for (int i = 0; i < 120 && rsps < 2; i++) begin
      @(negedge pclk);
      if (drop) begin req_valid = 1'b0; drop = 0; end
      if (rsp_valid) begin
        rsps++;
        if (rsps == 1) begin
          t1 = cyc; drop = 1;
          check("b2b_rx1", s_rx, 8'h01);
          check("b2b_rsp1", rsp_data, 8'h55);
        end else begin
          check("b2b_lat2", cyc - t1, 37);
          check("b2b_rx2", s_rx, 8'h80);
        end
      end
      if (rsps < 2 && cs[0]) high++;
    end
    req_valid = 1'b0;
    check("b2b_frames", rsps, 2);
    check("b2b_cs_gap", high, 1);

    // reset in the middle of a frame
    @(negedge pclk);
    req_valid = 1'b1; req_data = 8'h3C; req_cs_sel = 3'd1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge pclk);
    @(negedge pclk);
    req_valid = 1'b0; n = cyc;
    for (int i = 0; i < 20 && cyc < n + 10; i++) @(negedge pclk);
    areset = 1'b1;
    @(negedge pclk);
    check("abort_cs_sclk_rsp", {cs, sclk, rsp_valid, busy}, {4'hF, 1'b0, 1'b0, 1'b0});
    areset = 1'b0;
    cnt_rsp = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge pclk);
      if (rsp_valid) cnt_rsp++;
    end
    check("abort_no_rsp", cnt_rsp, 0);
    run_frame('{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'hD2, 8'h4B, 8'h4B, 4'b1011});

    // CLK_DIV=1 instance, mode 1, loopback
    @(negedge pclk);
    cpol = 1'b0; cpha = 1'b1; lsb_first = 1'b0; req_data = 8'hB4;
    @(negedge pclk);
    req_valid2 = 1'b1;
    for (int i = 0; i < 50 && !req_ready2; i++) @(negedge pclk);
    @(negedge pclk);
    req_valid2 = 1'b0; n = cyc;
    toggles = 0; first = -1; last = -1; seen = 0; prev = sclk2; got = 8'h00; t1 = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge pclk);
      if (sclk2 != prev) begin
        toggles++;
        if (first < 0) first = cyc;
        last = cyc; prev = sclk2;
      end
      if (rsp_valid2) begin seen = 1; t1 = cyc - n; got = rsp_data2; end
    end
    check("div1_latency", t1, 20);
    check("div1_rsp", got, 8'hB4);
    check("div1_toggles", toggles, 16);
    check("div1_span", last - first, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
